uart_tx_fifo: RTL and testbench

Transmit-side byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the peripheral register interface into a DEPTH-entry FIFO, then drains them one at a time into the transmitter using its `tx_data`/`tx_start`/`tx_busy` handshake. It holds each byte stable for the whole frame and issues back-to-back launches with no software pacing.

---
 rtl/uart_tx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO with a launch controller driving the UART transmitter
// through a tx_data/tx_start/tx_busy handshake.
//
//   state   | meaning
//   F_IDLE  | no launch outstanding; pop as soon as a byte is queued and tx is free
//   F_START | tx_start held high until the transmitter reports busy
//   F_WAIT  | frame in flight; tx_data held until tx_busy falls
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_uart,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  input  logic          clr_overflow,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          tx_idle,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy
);

  typedef enum logic [1:0] {F_IDLE, F_START, F_WAIT} fsm_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fsm_t          state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, ovf_set, tx_start_nxt;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full && !flush;
  assign ovf_set = wr_en && full && !flush;
  assign tx_idle = empty && (state == F_IDLE) && !tx_busy;

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    tx_start_nxt = 1'b0;
    case (state)
      F_IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop          = 1'b1;
          tx_start_nxt = 1'b1;
          state_nxt    = F_START;
        end
      end
      F_START: begin
        tx_start_nxt = 1'b1;
        if (tx_busy) begin
          tx_start_nxt = 1'b0;
          state_nxt    = F_WAIT;
        end
      end
      F_WAIT: begin
        // Relaunch straight from WAIT so frames go out back to back.
        if (!tx_busy) begin
          if (!empty && !flush) begin
            pop          = 1'b1;
            tx_start_nxt = 1'b1;
            state_nxt    = F_START;
          end else begin
            state_nxt = F_IDLE;
          end
        end
      end
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      state    <= F_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_start <= tx_start_nxt;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_uart) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Flush clears the queue only; the byte already in tx_data keeps going.
  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_uart or negedge rst) begin
    if (!rst)              overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model checked every cycle,
// a simple transmitter stand-in, directed scenarios and a random phase.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk_uart = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        hold_busy = 1'b0;
  logic        full, empty, overflow, tx_idle, tx_start, tx_busy;
  logic [AW:0] count;
  logic [7:0]  tx_data;

  int total = 0;
  int bad = 0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_uart(clk_uart), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .clr_overflow(clr_overflow), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_idle(tx_idle), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk_uart = ~clk_uart;

  // transmitter stand-in: accepts tx_start when free, stays busy frame_len cycles
  logic       busy_q;
  int         busy_cnt;
  int         frame_len = 10;
  logic [7:0] sent[$];

  assign tx_busy = busy_q | hold_busy;

  always @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      busy_cnt <= 0;
    end else if (busy_q) begin
      if (busy_cnt <= 1) busy_q <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end else if (tx_start) begin
      busy_q   <= 1'b1;
      busy_cnt <= frame_len;
      sent.push_back(tx_data);
    end
  end

  // reference model: a byte queue plus "launch pending" / "frame running" flags
  logic [7:0] mq[$];
  logic       m_start, m_wait, m_ovf;
  logic [7:0] m_data;
  bit         was_full, launch;

  always @(posedge clk_uart or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_start = 1'b0;
      m_wait  = 1'b0;
      m_ovf   = 1'b0;
      m_data  = 8'h00;
    end else begin
      was_full = (mq.size() == DEPTH);
      launch   = !m_start && !tx_busy && (mq.size() != 0) && !flush;
      if (launch) begin
        m_data  = mq.pop_front();
        m_start = 1'b1;
        m_wait  = 1'b0;
      end else if (m_start && tx_busy) begin
        m_start = 1'b0;
        m_wait  = 1'b1;
      end else if (m_wait && !tx_busy) begin
        m_wait = 1'b0;
      end
      if (flush) mq.delete();
      else if (wr_en && !was_full) mq.push_back(wr_data);
      if (wr_en && was_full && !flush) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_uart) begin
    if (rst) begin
      check("m_count",    int'(count),    mq.size());
      check("m_full",     int'(full),     int'(mq.size() == DEPTH));
      check("m_empty",    int'(empty),    int'(mq.size() == 0));
      check("m_tx_start", int'(tx_start), int'(m_start));
      check("m_tx_data",  int'(tx_data),  int'(m_data));
      check("m_overflow", int'(overflow), int'(m_ovf));
      check("m_tx_idle",  int'(tx_idle),
            int'(mq.size() == 0 && !m_start && !m_wait && !tx_busy));
    end
  end

  task automatic tick();
    @(posedge clk_uart);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (!tx_busy && n < 100) begin tick(); n++; end
    while (tx_busy && n < 400) begin tick(); n++; end
    check("frame_end_timeout", int'(n < 400), 1);
  endtask

  task automatic wait_start();
    int n = 0;
    while (!tx_start && n < 400) begin tick(); n++; end
    check("start_timeout", int'(n < 400), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (!(tx_idle && empty) && n < 3000) begin tick(); n++; end
    check("drain_timeout", int'(n < 3000), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_start"}, int'(tx_start), 0);
    check({tag, "_tx_data"},  int'(tx_data),  0);
    check({tag, "_count"},    int'(count),    0);
    check({tag, "_empty"},    int'(empty),    1);
    check({tag, "_full"},     int'(full),     0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_tx_idle"},  int'(tx_idle),  1);
  endtask

  initial begin
    int n0;
    bit  leaked;

    repeat (3) tick();
    check_reset_values("por");
    rst = 1'b1;
    tick();

    // first-byte latency with A5
    push(8'hA5);
    check("lat_count_n", int'(count), 1);
    check("lat_start_n", int'(tx_start), 0);
    tick();
    check("lat_start_n1", int'(tx_start), 1);
    check("lat_data_n1", int'(tx_data), 8'hA5);
    check("lat_count_n1", int'(count), 0);
    tick();
    check("lat_start_n2", int'(tx_start), 1);
    check("lat_busy_n2", int'(tx_busy), 1);
    tick();
    check("lat_start_n3", int'(tx_start), 0);
    wait_frame_end();
    check("a5_data_held", int'(tx_data), 8'hA5);
    tick();
    check("a5_idle", int'(tx_idle), 1);
    check("a5_sent", int'(sent[sent.size()-1]), 8'hA5);

    // three back-to-back frames
    n0 = sent.size();
    push(8'h01); push(8'h02); push(8'h03);
    for (int k = 1; k <= 2; k++) begin
      wait_frame_end();
      tick();
      check("b2b_start", int'(tx_start), 1);
      check("b2b_count", int'(count), 2 - k);
      check("b2b_data", int'(tx_data), k + 1);
    end
    drain();
    check("b2b_frames", sent.size() - n0, 3);
    check("b2b_order0", int'(sent[n0]),   8'h01);
    check("b2b_order2", int'(sent[n0+2]), 8'h03);

    // fill to DEPTH with transmitter held busy, then overflow
    hold_busy = 1'b1;
    n0 = sent.size();
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);
    check("fill_ovf0", int'(overflow), 0);
    push(8'hEE);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count", int'(count), 16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_clr", int'(overflow), 0);
    // push while full in the same cycle as a launch
    hold_busy = 1'b0;
    push(8'hDD);
    check("fullpop_count", int'(count), 15);
    check("fullpop_ovf", int'(overflow), 1);
    check("fullpop_data", int'(tx_data), 8'h10);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    drain();
    check("fill_frames", sent.size() - n0, 16);
    leaked = 1'b0;
    for (int i = n0; i < sent.size(); i++)
      if (sent[i] == 8'hEE || sent[i] == 8'hDD) leaked = 1'b1;
    check("fill_no_dropped", int'(leaked), 0);

    // simultaneous push and pop at count=3
    hold_busy = 1'b1;
    push(8'h21); push(8'h22); push(8'h23);
    check("pp_count_pre", int'(count), 3);
    hold_busy = 1'b0;
    push(8'h24);
    check("pp_count", int'(count), 3);
    check("pp_start", int'(tx_start), 1);
    drain();

    // flush during frame of byte 0
    n0 = sent.size();
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    check("fl_count_pre", int'(count), 5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_count", int'(count), 0);
    check("fl_empty", int'(empty), 1);
    wait_frame_end();
    tick();
    tick();
    check("fl_idle", int'(tx_idle), 1);
    check("fl_start", int'(tx_start), 0);
    check("fl_frames", sent.size() - n0, 1);
    check("fl_data", int'(tx_data), 8'h40);

    // reset mid-frame with overflow set and bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) push(8'h80 + 8'(i));
    hold_busy = 1'b0;
    wait_start();
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_after_count", int'(count), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      wr_en        = ($urandom_range(0, 99) < 45);
      wr_data      = 8'($urandom);
      flush        = ($urandom_range(0, 99) < 2);
      clr_overflow = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) hold_busy = ~hold_busy;
      frame_len    = $urandom_range(2, 14);
      tick();
    end
    wr_en = 1'b0;
    flush = 1'b0;
    clr_overflow = 1'b0;
    hold_busy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
